mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, SHALL mean cycles from the mem_req cycle to the cycle mem_rdata is valid (legal range 1..15).
REQ-002 Parameter STARVE_LIMIT, default 3, SHALL mean the maximum number of consecutive DM grants while if_req is pending.
REQ-003 CLK  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 RST  in  1  synchronous, active-low reset.
REQ-005 if_req in 1 fetch request; if_addr in 64 fetch address.
REQ-006 if_valid out 1 fetch completion pulse; if_rdata out 32 fetched instruction, mem_rdata[31:0].
REQ-007 dm_req in 1; dm_we in 1; dm_addr in 64; dm_wdata in 64: data-stage access.
REQ-008 dm_valid out 1 data completion pulse; dm_rdata out 64 load data.
REQ-009 mem_req out 1; mem_we out 1; mem_addr out 64; mem_wdata out 64; mem_rdata in 64: single shared memory port.
REQ-010 stall_if out 1; stall_mem out 1: pipeline freeze requests for the IF and MEM stages.

Function
REQ-011 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-012 IDLE: with any request pending at the edge, the FSM SHALL latch the winner (owner, addr, we, wdata) and go to ISSUE; otherwise it stays in IDLE.
REQ-013 Arbitration: DM SHALL win over IF, except IF SHALL win when if_req=1 and streak==STARVE_LIMIT.
REQ-014 streak: +1 on each DM grant while if_req=1; cleared on an IF grant or when if_req=0; saturates at STARVE_LIMIT.
REQ-015 ISSUE lasts 1 cycle with mem_req=1, then the FSM goes to WAIT.
REQ-016 WAIT lasts exactly MEM_LAT cycles, counted by a down-counter loaded with MEM_LAT-1 on entry.
REQ-017 On the last WAIT cycle, reads SHALL capture mem_rdata into the owner's rdata register.
REQ-018 Writes SHALL leave dm_rdata unchanged.
REQ-019 RESP lasts 1 cycle: the owner's valid=1; the FSM then always returns to IDLE, with no back-to-back issue.
REQ-020 mem_addr, mem_we and mem_wdata SHALL hold the latched values through ISSUE, WAIT and RESP, and SHALL be 0 in IDLE.
REQ-021 mem_req=1 only in ISSUE, and mem_we=1 only for a DM write.
REQ-022 Latency from request sampled in IDLE to valid SHALL be MEM_LAT+2 cycles.
REQ-023 Requester contract: req and its attributes are held until valid and deasserted in the cycle after valid.
REQ-024 stall_if = if_req & ~if_valid; stall_mem = dm_req & ~dm_valid (combinational).
REQ-025 Request dropped mid-transaction: the access SHALL complete and valid SHALL still pulse.
REQ-026 Simultaneous if_req and dm_req in IDLE SHALL be resolved per REQ-013; the loser remains pending with stall asserted.
REQ-027 if_rdata and dm_rdata SHALL hold their last captured value between accesses.

Reset
REQ-028 RST=0 at an edge SHALL force IDLE, streak=0, counter=0, latched fields=0, if_rdata=0, dm_rdata=0.
REQ-029 After reset, all outputs SHALL be 0 except the stalls, which follow the requests.
REQ-030 Reset mid-transaction SHALL abort it with no valid pulse; mem_req SHALL be 0 from the next cycle.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the state enum, the owner enum (OWN_IF, OWN_DM), and the default MEM_LAT and STARVE_LIMIT constants.
REQ-032 The WAIT down-counter SHALL be the sub-module mem_lat_counter (load, dec, zero flag); the remainder is the top-level FSM.

Verification (MEM_LAT=2, STARVE_LIMIT=3)
REQ-033 dm_req=1, dm_we=0, dm_addr=0x10, req at edge 0, mem_rdata=0xDEAD_BEEF in cycle 3 -> mem_req in cycle 1 only, dm_valid in cycle 4, dm_rdata=0xDEADBEEF, stall_mem=1 in cycles 0-3.
REQ-034 if_req and dm_req together in IDLE -> DM served first; if_valid 5 cycles after dm_valid; stall_if=1 throughout.
REQ-035 dm_req held continuously with if_req=1 -> 3 DM grants, then 1 IF grant, then DM resumes.
REQ-036 DM write, addr=0x8, wdata=0x55 -> mem_we=1 with mem_addr=0x8 and mem_wdata=0x55 in cycle 1; dm_valid in cycle 4; dm_rdata unchanged.
REQ-037 RST=0 in WAIT cycle 2 -> no valid pulse; cycle 3 IDLE; all outputs 0; a fresh request is served normally.
REQ-038 dm_req dropped in cycle 2 -> dm_valid still pulses in cycle 4; the FSM is in IDLE in cycle 5.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Purpose: shared types and constants for the instruction/data memory port arbiter.
// Contents: FSM state enum, access-owner enum, default latency/starvation limits, widths.
// Latency/backpressure: n/a (types only).
package mem_arb_pkg;

   localparam int unsigned MEM_LAT_DEF      = 2;
   localparam int unsigned STARVE_LIMIT_DEF = 3;

   localparam int unsigned ADDR_W   = 64;
   localparam int unsigned DATA_W   = 64;
   localparam int unsigned INSN_W   = 32;
   // Wide enough to hold MEM_LAT-1 for MEM_LAT up to 15.
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned STREAK_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch, data-stage and shared-memory signals of the arbiter.
// Ports: slave = arbiter view (takes requests and mem_rdata, drives completions/memory/stalls);
//        master = requester/memory-model view (the mirror image).
interface mem_port_arbiter_if;
   import mem_arb_pkg::*;

   // fetch side
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_valid;
   logic [INSN_W-1:0] if_rdata;

   // data-stage side
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_valid;
   logic [DATA_W-1:0] dm_rdata;

   // shared memory port
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // pipeline freeze requests
   logic              stall_if;
   logic              stall_mem;

   modport slave (
      input  if_req, if_addr,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  mem_rdata,
      output if_valid, if_rdata,
      output dm_valid, dm_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output stall_if, stall_mem
   );

   modport master (
      output if_req, if_addr,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output mem_rdata,
      input  if_valid, if_rdata,
      input  dm_valid, dm_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  stall_if, stall_mem
   );

endinterface

// File: rtl/mem_port_arbiter_counter.sv
// Purpose: down-counter timing the memory wait window (load, decrement, zero flag).
// Ports: clk, rst (sync, active-low), load/load_val, dec, zero.
// Latency: load/dec take effect at the next rising edge; zero is combinational from the count.
module mem_lat_counter
   import mem_arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates fetch (IF) and data-stage (DM) accesses onto one shared memory port.
// Latency: request sampled in IDLE -> owner valid pulse MEM_LAT+2 cycles later; one idle cycle between accesses.
// Backpressure: the losing/waiting requester sees its stall output until its valid pulse.
// Ports: clk, rst (sync, active-low), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_LAT      = MEM_LAT_DEF,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0]    LAT_LOAD = CNT_W'(MEM_LAT - 1);
   localparam logic [STREAK_W-1:0] LIMIT    = STREAK_W'(STARVE_LIMIT);

   state_t              state;
   owner_t              owner;
   logic [ADDR_W-1:0]   addr_q;
   logic                we_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                mem_req_q;
   logic                if_valid_q;
   logic                dm_valid_q;
   logic [INSN_W-1:0]   if_rdata_q;
   logic [DATA_W-1:0]   dm_rdata_q;
   logic [STREAK_W-1:0] streak;

   logic grant_if;
   logic grant_dm;
   logic cnt_load;
   logic cnt_dec;
   logic cnt_zero;

   // DM normally wins; a fetch that has watched STARVE_LIMIT DM grants in a row gets the port.
   always_comb begin
      grant_if = bus.if_req & (~bus.dm_req | (streak == LIMIT));
      grant_dm = bus.dm_req & ~grant_if;
   end

   // Counter is loaded as ISSUE hands over to WAIT, so WAIT spans exactly MEM_LAT cycles.
   always_comb begin
      cnt_load = (state == ISSUE);
      cnt_dec  = (state == WAIT) & ~cnt_zero;
   end

   mem_lat_counter u_lat_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (LAT_LOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         owner      <= OWN_IF;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         mem_req_q  <= 1'b0;
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         streak     <= '0;
      end else begin
         // single-cycle pulses by default
         mem_req_q  <= 1'b0;
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;

         // Streak only counts DM wins that actually kept a fetch waiting.
         if (!bus.if_req) begin
            streak <= '0;
         end else if (state == IDLE) begin
            if (grant_if) begin
               streak <= '0;
            end else if (grant_dm && (streak != LIMIT)) begin
               streak <= streak + STREAK_W'(1);
            end
         end

         case (state)
            IDLE: begin
               if (grant_if || grant_dm) begin
                  state     <= ISSUE;
                  mem_req_q <= 1'b1;
                  owner     <= grant_if ? OWN_IF : OWN_DM;
                  addr_q    <= grant_if ? bus.if_addr : bus.dm_addr;
                  we_q      <= grant_dm & bus.dm_we;
                  wdata_q   <= grant_dm ? bus.dm_wdata : '0;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (cnt_zero) begin
                  state <= RESP;
                  if (owner == OWN_IF) begin
                     if_rdata_q <= bus.mem_rdata[INSN_W-1:0];
                     if_valid_q <= 1'b1;
                  end else begin
                     if (!we_q) begin
                        dm_rdata_q <= bus.mem_rdata;
                     end
                     dm_valid_q <= 1'b1;
                  end
               end
            end
            RESP: begin
               // Always pass through IDLE so the memory bus reads back as zero between accesses.
               state   <= IDLE;
               addr_q  <= '0;
               we_q    <= 1'b0;
               wdata_q <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_valid  = dm_valid_q;
   assign bus.dm_rdata  = dm_rdata_q;

   assign bus.stall_if  = bus.if_req & ~if_valid_q;
   assign bus.stall_mem = bus.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed bench for mem_port_arbiter with MEM_LAT=2, STARVE_LIMIT=3.
// Inputs change 1 ns after a rising edge; outputs are observed on the falling edge.
// Cycle c of a scenario is the c-th clock period after its start; requests set in cycle 0 are sampled at its closing edge.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.MEM_LAT(2), .STARVE_LIMIT(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.dm_req    = 1'b0;
      bus.dm_we     = 1'b0;
      bus.dm_addr   = '0;
      bus.dm_wdata  = '0;
      bus.mem_rdata = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      bus.if_req = 1'b1;
      repeat (3) tick();
      mid();
      n_checks++; if ({bus.mem_req, bus.mem_we, bus.if_valid, bus.dm_valid} !== 4'b0000) begin n_fail++; $display("FAIL reset.ctrl got=%b exp=0000", {bus.mem_req, bus.mem_we, bus.if_valid, bus.dm_valid}); end
      n_checks++; if (bus.mem_addr !== 64'h0) begin n_fail++; $display("FAIL reset.mem_addr got=%h exp=0", bus.mem_addr); end
      n_checks++; if (bus.mem_wdata !== 64'h0) begin n_fail++; $display("FAIL reset.mem_wdata got=%h exp=0", bus.mem_wdata); end
      n_checks++; if (bus.if_rdata !== 32'h0) begin n_fail++; $display("FAIL reset.if_rdata got=%h exp=0", bus.if_rdata); end
      n_checks++; if (bus.dm_rdata !== 64'h0) begin n_fail++; $display("FAIL reset.dm_rdata got=%h exp=0", bus.dm_rdata); end
      n_checks++; if ({bus.stall_if, bus.stall_mem} !== 2'b10) begin n_fail++; $display("FAIL reset.stalls got=%b exp=10", {bus.stall_if, bus.stall_mem}); end
      tick();
      bus.if_req = 1'b0;
      rst = 1'b1;
      mid();
      n_checks++; if ({bus.stall_if, bus.mem_req} !== 2'b00) begin n_fail++; $display("FAIL reset.release got=%b exp=00", {bus.stall_if, bus.mem_req}); end
   endtask

   task automatic test_dm_read();
      for (int c = 0; c <= 5; c++) begin
         tick();
         case (c)
            0: begin bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h10; end
            3: bus.mem_rdata = 64'hDEAD_BEEF;
            4: bus.mem_rdata = '0;
            5: begin bus.dm_req = 1'b0; bus.dm_addr = '0; end
            default: ;
         endcase
         mid();
         n_checks++; if (bus.mem_req !== (c == 1)) begin n_fail++; $display("FAIL dm_read.mem_req c%0d got=%b exp=%b", c, bus.mem_req, (c == 1)); end
         n_checks++; if (bus.stall_mem !== (c <= 3)) begin n_fail++; $display("FAIL dm_read.stall_mem c%0d got=%b exp=%b", c, bus.stall_mem, (c <= 3)); end
         n_checks++; if (bus.dm_valid !== (c == 4)) begin n_fail++; $display("FAIL dm_read.dm_valid c%0d got=%b exp=%b", c, bus.dm_valid, (c == 4)); end
         if (c == 1) begin
            n_checks++; if (bus.mem_addr !== 64'h10) begin n_fail++; $display("FAIL dm_read.mem_addr c1 got=%h exp=10", bus.mem_addr); end
         end
         if (c == 4) begin
            n_checks++; if (bus.dm_rdata !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL dm_read.dm_rdata c4 got=%h exp=deadbeef", bus.dm_rdata); end
         end
         if (c == 5) begin
            n_checks++; if (bus.mem_addr !== 64'h0) begin n_fail++; $display("FAIL dm_read.idle_addr c5 got=%h exp=0", bus.mem_addr); end
            n_checks++; if (bus.dm_rdata !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL dm_read.rdata_hold c5 got=%h exp=deadbeef", bus.dm_rdata); end
         end
      end
   endtask

   task automatic test_dm_write();
      for (int c = 0; c <= 5; c++) begin
         tick();
         case (c)
            0: begin bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 64'h8; bus.dm_wdata = 64'h55; bus.mem_rdata = 64'h1234_5678; end
            5: begin clear_inputs(); end
            default: ;
         endcase
         mid();
         n_checks++; if (bus.mem_req !== (c == 1)) begin n_fail++; $display("FAIL dm_write.mem_req c%0d got=%b exp=%b", c, bus.mem_req, (c == 1)); end
         n_checks++; if (bus.dm_valid !== (c == 4)) begin n_fail++; $display("FAIL dm_write.dm_valid c%0d got=%b exp=%b", c, bus.dm_valid, (c == 4)); end
         n_checks++; if (bus.mem_we !== ((c >= 1) && (c <= 4))) begin n_fail++; $display("FAIL dm_write.mem_we c%0d got=%b exp=%b", c, bus.mem_we, ((c >= 1) && (c <= 4))); end
         if (c == 1 || c == 3) begin
            n_checks++; if (bus.mem_addr !== 64'h8) begin n_fail++; $display("FAIL dm_write.mem_addr c%0d got=%h exp=8", c, bus.mem_addr); end
            n_checks++; if (bus.mem_wdata !== 64'h55) begin n_fail++; $display("FAIL dm_write.mem_wdata c%0d got=%h exp=55", c, bus.mem_wdata); end
         end
         if (c == 4) begin
            n_checks++; if (bus.dm_rdata !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL dm_write.rdata_unchanged c4 got=%h exp=deadbeef", bus.dm_rdata); end
         end
         if (c == 5) begin
            n_checks++; if (bus.mem_wdata !== 64'h0) begin n_fail++; $display("FAIL dm_write.idle_wdata c5 got=%h exp=0", bus.mem_wdata); end
         end
      end
   endtask

   task automatic test_simultaneous();
      for (int c = 0; c <= 10; c++) begin
         tick();
         case (c)
            0: begin bus.if_req = 1'b1; bus.if_addr = 64'h100; bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h20; end
            3: bus.mem_rdata = 64'hA5A5_0000_1234_5678;
            4: bus.mem_rdata = '0;
            5: begin bus.dm_req = 1'b0; bus.dm_addr = '0; end
            8: bus.mem_rdata = 64'hFFFF_FFFF_0BAD_F00D;
            9: bus.mem_rdata = '0;
            10: begin bus.if_req = 1'b0; bus.if_addr = '0; end
            default: ;
         endcase
         mid();
         n_checks++; if (bus.stall_if !== (c <= 8)) begin n_fail++; $display("FAIL simul.stall_if c%0d got=%b exp=%b", c, bus.stall_if, (c <= 8)); end
         n_checks++; if (bus.dm_valid !== (c == 4)) begin n_fail++; $display("FAIL simul.dm_valid c%0d got=%b exp=%b", c, bus.dm_valid, (c == 4)); end
         n_checks++; if (bus.if_valid !== (c == 9)) begin n_fail++; $display("FAIL simul.if_valid c%0d got=%b exp=%b", c, bus.if_valid, (c == 9)); end
         n_checks++; if (bus.mem_req !== (c == 1 || c == 6)) begin n_fail++; $display("FAIL simul.mem_req c%0d got=%b exp=%b", c, bus.mem_req, (c == 1 || c == 6)); end
         if (c == 1) begin
            n_checks++; if (bus.mem_addr !== 64'h20) begin n_fail++; $display("FAIL simul.dm_first c1 got=%h exp=20", bus.mem_addr); end
         end
         if (c == 4) begin
            n_checks++; if (bus.dm_rdata !== 64'hA5A5_0000_1234_5678) begin n_fail++; $display("FAIL simul.dm_rdata c4 got=%h exp=a5a5000012345678", bus.dm_rdata); end
         end
         if (c == 6) begin
            n_checks++; if (bus.mem_addr !== 64'h100) begin n_fail++; $display("FAIL simul.if_addr c6 got=%h exp=100", bus.mem_addr); end
         end
         if (c == 9) begin
            n_checks++; if (bus.if_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL simul.if_rdata c9 got=%h exp=0badf00d", bus.if_rdata); end
         end
      end
   endtask

   task automatic test_starvation();
      logic [63:0] exp_addr [5];
      exp_addr[0] = 64'h40;
      exp_addr[1] = 64'h40;
      exp_addr[2] = 64'h40;
      exp_addr[3] = 64'h200;
      exp_addr[4] = 64'h40;
      for (int c = 0; c <= 26; c++) begin
         tick();
         case (c)
            0: begin bus.if_req = 1'b1; bus.if_addr = 64'h200; bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h40; bus.mem_rdata = 64'h1111_2222; end
            20: begin bus.if_req = 1'b0; bus.if_addr = '0; end
            25: begin bus.dm_req = 1'b0; bus.dm_addr = '0; end
            26: bus.mem_rdata = '0;
            default: ;
         endcase
         mid();
         n_checks++; if (bus.mem_req !== ((c % 5 == 1) && (c <= 21))) begin n_fail++; $display("FAIL starve.mem_req c%0d got=%b exp=%b", c, bus.mem_req, ((c % 5 == 1) && (c <= 21))); end
         n_checks++; if (bus.if_valid !== (c == 19)) begin n_fail++; $display("FAIL starve.if_valid c%0d got=%b exp=%b", c, bus.if_valid, (c == 19)); end
         n_checks++; if (bus.dm_valid !== ((c % 5 == 4) && (c != 19) && (c <= 24))) begin n_fail++; $display("FAIL starve.dm_valid c%0d got=%b exp=%b", c, bus.dm_valid, ((c % 5 == 4) && (c != 19) && (c <= 24))); end
         n_checks++; if (bus.stall_if !== (c <= 18)) begin n_fail++; $display("FAIL starve.stall_if c%0d got=%b exp=%b", c, bus.stall_if, (c <= 18)); end
         if ((c % 5 == 1) && (c <= 21)) begin
            n_checks++; if (bus.mem_addr !== exp_addr[c / 5]) begin n_fail++; $display("FAIL starve.grant%0d_addr c%0d got=%h exp=%h", c / 5, c, bus.mem_addr, exp_addr[c / 5]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c <= 10; c++) begin
         tick();
         case (c)
            0: begin bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h30; end
            2: rst = 1'b0;
            3: begin rst = 1'b1; bus.dm_req = 1'b0; bus.dm_addr = '0; end
            5: begin bus.dm_req = 1'b1; bus.dm_addr = 64'h18; end
            8: bus.mem_rdata = 64'h77;
            9: bus.mem_rdata = '0;
            10: begin bus.dm_req = 1'b0; bus.dm_addr = '0; end
            default: ;
         endcase
         mid();
         n_checks++; if (bus.mem_req !== (c == 1 || c == 6)) begin n_fail++; $display("FAIL rst_mid.mem_req c%0d got=%b exp=%b", c, bus.mem_req, (c == 1 || c == 6)); end
         n_checks++; if (bus.dm_valid !== (c == 9)) begin n_fail++; $display("FAIL rst_mid.dm_valid c%0d got=%b exp=%b", c, bus.dm_valid, (c == 9)); end
         if (c == 3) begin
            n_checks++; if (bus.mem_addr !== 64'h0) begin n_fail++; $display("FAIL rst_mid.mem_addr c3 got=%h exp=0", bus.mem_addr); end
            n_checks++; if (bus.dm_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_mid.dm_rdata c3 got=%h exp=0", bus.dm_rdata); end
            n_checks++; if (bus.if_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid.if_rdata c3 got=%h exp=0", bus.if_rdata); end
            n_checks++; if ({bus.mem_we, bus.if_valid, bus.stall_mem} !== 3'b000) begin n_fail++; $display("FAIL rst_mid.ctrl c3 got=%b exp=000", {bus.mem_we, bus.if_valid, bus.stall_mem}); end
         end
         if (c == 6) begin
            n_checks++; if (bus.mem_addr !== 64'h18) begin n_fail++; $display("FAIL rst_mid.fresh_addr c6 got=%h exp=18", bus.mem_addr); end
         end
         if (c == 9) begin
            n_checks++; if (bus.dm_rdata !== 64'h77) begin n_fail++; $display("FAIL rst_mid.fresh_rdata c9 got=%h exp=77", bus.dm_rdata); end
         end
      end
   endtask

   task automatic test_drop();
      for (int c = 0; c <= 6; c++) begin
         tick();
         case (c)
            0: begin bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h50; end
            2: begin bus.dm_req = 1'b0; bus.dm_addr = '0; end
            3: bus.mem_rdata = 64'h99;
            4: bus.mem_rdata = '0;
            default: ;
         endcase
         mid();
         n_checks++; if (bus.mem_req !== (c == 1)) begin n_fail++; $display("FAIL drop.mem_req c%0d got=%b exp=%b", c, bus.mem_req, (c == 1)); end
         n_checks++; if (bus.dm_valid !== (c == 4)) begin n_fail++; $display("FAIL drop.dm_valid c%0d got=%b exp=%b", c, bus.dm_valid, (c == 4)); end
         n_checks++; if (bus.stall_mem !== (c <= 1)) begin n_fail++; $display("FAIL drop.stall_mem c%0d got=%b exp=%b", c, bus.stall_mem, (c <= 1)); end
         if (c == 3) begin
            n_checks++; if (bus.mem_addr !== 64'h50) begin n_fail++; $display("FAIL drop.addr_hold c3 got=%h exp=50", bus.mem_addr); end
         end
         if (c == 4) begin
            n_checks++; if (bus.dm_rdata !== 64'h99) begin n_fail++; $display("FAIL drop.dm_rdata c4 got=%h exp=99", bus.dm_rdata); end
         end
         if (c == 5) begin
            n_checks++; if (bus.mem_addr !== 64'h0) begin n_fail++; $display("FAIL drop.idle_addr c5 got=%h exp=0", bus.mem_addr); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_dm_read();
      test_dm_write();
      test_simultaneous();
      test_starvation();
      test_reset_mid();
      test_drop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
